// File: rtl/usb_frame_scheduler.sv
// ---------------------------------------------------------------------------
// usb_frame_scheduler
//
// Purpose:
//   Host-side transaction sequencer for the shared ULPI TX/RX engine. Owns the
//   full-speed frame timer, issues an SOF at every frame start, and arbitrates
//   the engine between SOF, the control-transfer requester and periodic
//   interrupt-IN polling. New CTRL/INTR grants are refused inside the
//   end-of-frame guard window so no transaction straddles an SOF.
//
// Parameters:
//   CLK_PER_FRAME  clocks per frame (>= EOF_GUARD+2)
//   EOF_GUARD      cycles before frame end in which CTRL/INTR are refused
//   POLL_INTERVAL  frames between interrupt-IN polls (>= 1)
//
// Ports:
//   clk           ULPI clock
//   rst_n         synchronous reset, active low
//   enable_i      device connected; 0 holds scheduler idle/cleared
//   disconnect_i  host disconnect; same effect as enable_i=0
//   ctrl_req_i    control engine wants the bus (level, held until granted)
//   intr_en_i     interrupt endpoint configured; gates INTR grants
//   txn_done_i    1-cycle pulse: granted transaction finished
//   sof_gnt_o     engine must send SOF with frame_num_o
//   ctrl_gnt_o    control requester owns the engine
//   intr_gnt_o    engine must issue IN token to the interrupt endpoint
//   frame_num_o   frame number carried by the current/next SOF
//   eof_window_o  frame counter is inside the guard window
//   busy_o        any grant asserted
// ---------------------------------------------------------------------------
module usb_frame_scheduler #(
  parameter int unsigned CLK_PER_FRAME = 60000,
  parameter int unsigned EOF_GUARD     = 600,
  parameter int unsigned POLL_INTERVAL = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        disconnect_i,
  input  logic        ctrl_req_i,
  input  logic        intr_en_i,
  input  logic        txn_done_i,
  output logic        sof_gnt_o,
  output logic        ctrl_gnt_o,
  output logic        intr_gnt_o,
  output logic [10:0] frame_num_o,
  output logic        eof_window_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W  = (CLK_PER_FRAME > 2) ? $clog2(CLK_PER_FRAME) : 1;
  localparam int unsigned POLL_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_PER_FRAME - 1);
  localparam logic [CNT_W-1:0]  EOF_START = CNT_W'(CLK_PER_FRAME - EOF_GUARD);
  localparam logic [POLL_W-1:0] POLL_LOAD = POLL_W'(POLL_INTERVAL - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOF  = 2'd1,
    ST_CTRL = 2'd2,
    ST_INTR = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [10:0]        frame_num_q, frame_num_d;
  logic               sof_pend_q, sof_pend_d;
  logic               intr_due_q, intr_due_d;
  logic [POLL_W-1:0]  poll_cnt_q, poll_cnt_d;

  logic clear;
  logic frame_start;
  logic eof_window;
  logic sof_issue;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      frame_num_q <= '0;
      sof_pend_q  <= 1'b0;
      intr_due_q  <= 1'b0;
      poll_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      frame_num_q <= frame_num_d;
      sof_pend_q  <= sof_pend_d;
      intr_due_q  <= intr_due_d;
      poll_cnt_q  <= poll_cnt_d;
    end
  end

  always_comb begin
    clear       = !enable_i || disconnect_i;
    frame_start = !clear && (frame_cnt_q == '0);
    eof_window  = !clear && (frame_cnt_q >= EOF_START);
    sof_issue   = 1'b0;

    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    frame_num_d = frame_num_q;
    sof_pend_d  = sof_pend_q;
    intr_due_d  = intr_due_q;
    poll_cnt_d  = poll_cnt_q;

    if (clear) begin
      // Abort everything; the frame number survives so numbering resumes.
      state_d     = ST_IDLE;
      frame_cnt_d = '0;
      sof_pend_d  = 1'b0;
      intr_due_d  = 1'b0;
      poll_cnt_d  = '0;
    end else begin
      frame_cnt_d = (frame_cnt_q == CNT_LAST) ? '0 : frame_cnt_q + 1'b1;

      unique case (state_q)
        ST_IDLE: begin
          if (sof_pend_q) begin
            state_d   = ST_SOF;
            sof_issue = 1'b1;
          end else if (!frame_start && !eof_window) begin
            // The frame-start cycle is treated as SOF-pending: the pend flag
            // only becomes visible one cycle later, and a CTRL/INTR grant
            // here would push the SOF behind a whole transaction.
            if (ctrl_req_i) begin
              state_d = ST_CTRL;
            end else if (intr_due_q && intr_en_i) begin
              state_d = ST_INTR;
            end
          end
        end
        ST_SOF: begin
          if (txn_done_i) begin
            state_d     = ST_IDLE;
            frame_num_d = frame_num_q + 11'd1;
            if (poll_cnt_q == '0) begin
              intr_due_d = 1'b1;
              poll_cnt_d = POLL_LOAD;
            end else begin
              poll_cnt_d = poll_cnt_q - 1'b1;
            end
          end
        end
        ST_CTRL: begin
          if (txn_done_i) begin
            state_d = ST_IDLE;
          end
        end
        ST_INTR: begin
          if (txn_done_i) begin
            state_d    = ST_IDLE;
            intr_due_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // A new frame start must win over the issue of a stale pending SOF.
      sof_pend_d = (sof_pend_q && !sof_issue) || frame_start;
    end
  end

  assign sof_gnt_o    = (state_q == ST_SOF);
  assign ctrl_gnt_o   = (state_q == ST_CTRL);
  assign intr_gnt_o   = (state_q == ST_INTR);
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_num_o  = frame_num_q;
  assign eof_window_o = eof_window;

endmodule

// File: tb/tb_usb_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_usb_frame_scheduler
//
// Scoreboard bench: each expected grant (kind + frame number) is queued when
// the stimulus that causes it is driven; a monitor pops and compares on every
// grant start. Cycle-accurate timing points are checked inline.
// Parameters: CLK_PER_FRAME=100, EOF_GUARD=10, POLL_INTERVAL=2.
// ---------------------------------------------------------------------------
module tb_usb_frame_scheduler;

  localparam int CPF = 100;
  localparam int EG  = 10;
  localparam int PI  = 2;

  localparam logic [2:0] K_SOF  = 3'b001;
  localparam logic [2:0] K_CTRL = 3'b010;
  localparam logic [2:0] K_INTR = 3'b100;

  logic        clk;
  logic        rst_n;
  logic        enable_i;
  logic        disconnect_i;
  logic        ctrl_req_i;
  logic        intr_en_i;
  logic        txn_done_i;
  logic        sof_gnt_o;
  logic        ctrl_gnt_o;
  logic        intr_gnt_o;
  logic [10:0] frame_num_o;
  logic        eof_window_o;
  logic        busy_o;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int fc = 0;   // model of the frame counter value after the latest edge

  logic [13:0] sb_q[$];  // {kind[2:0], frame_num[10:0]}

  usb_frame_scheduler #(
    .CLK_PER_FRAME(CPF),
    .EOF_GUARD    (EG),
    .POLL_INTERVAL(PI)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable_i),
    .disconnect_i(disconnect_i),
    .ctrl_req_i  (ctrl_req_i),
    .intr_en_i   (intr_en_i),
    .txn_done_i  (txn_done_i),
    .sof_gnt_o   (sof_gnt_o),
    .ctrl_gnt_o  (ctrl_gnt_o),
    .intr_gnt_o  (intr_gnt_o),
    .frame_num_o (frame_num_o),
    .eof_window_o(eof_window_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; inputs are stable across the edge, outputs read #1 after.
  task automatic tick();
    bit en;
    en = rst_n && enable_i && !disconnect_i;
    @(posedge clk);
    #1;
    cyc++;
    if (!en) fc = 0;
    else     fc = (fc == CPF - 1) ? 0 : fc + 1;
  endtask

  task automatic expect_grant(input logic [2:0] kind, input int fn);
    sb_q.push_back({kind, 11'(fn)});
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (!busy_o && n < 300) begin
      tick();
      n++;
    end
    if (!busy_o) check("grant_timeout", {31'd0, busy_o}, 32'd1);
  endtask

  task automatic finish_txn();
    txn_done_i = 1'b1;
    tick();
    txn_done_i = 1'b0;
    check("grant_drop", {31'd0, busy_o}, 32'd0);
  endtask

  // Grant monitor: one line per transaction, compared against the scoreboard.
  initial begin : monitor
    logic [2:0]  prev_kind;
    logic [2:0]  kind_now;
    logic [13:0] exp_item;
    prev_kind = 3'b000;
    forever begin
      @(posedge clk);
      #1;
      kind_now = {intr_gnt_o, ctrl_gnt_o, sof_gnt_o};
      if (kind_now != 3'b000 && prev_kind == 3'b000) begin
        $display("[TB] cycle %0d grant kind=%b frame_num=%0d", cyc, kind_now, frame_num_o);
        check("busy_on_grant", {31'd0, busy_o}, 32'd1);
        if (sb_q.size() == 0) begin
          check("unexpected_grant", {29'd0, kind_now}, 32'd0);
        end else begin
          exp_item = sb_q.pop_front();
          check("grant_kind", {29'd0, kind_now}, {29'd0, exp_item[13:11]});
          check("grant_frame", {21'd0, frame_num_o}, {21'd0, exp_item[10:0]});
        end
      end
      prev_kind = kind_now;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst_n        = 1'b0;
    enable_i     = 1'b0;
    disconnect_i = 1'b0;
    ctrl_req_i   = 1'b0;
    intr_en_i    = 1'b0;
    txn_done_i   = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_sof",  {31'd0, sof_gnt_o}, 32'd0);
    check("rst_ctrl", {31'd0, ctrl_gnt_o}, 32'd0);
    check("rst_intr", {31'd0, intr_gnt_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_fn",   {21'd0, frame_num_o}, 32'd0);
    check("rst_eof",  {31'd0, eof_window_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Enable with control request already up: SOF must come first, on the
    // second enabled edge, then CTRL two edges after SOF completion.
    enable_i   = 1'b1;
    ctrl_req_i = 1'b1;
    expect_grant(K_SOF, 0);
    expect_grant(K_CTRL, 1);
    tick();
    check("en_first_edge_idle", {31'd0, busy_o}, 32'd0);
    check("en_eof_low", {31'd0, eof_window_o}, 32'd0);
    tick();
    check("en_sof", {31'd0, sof_gnt_o}, 32'd1);
    check("en_fn0", {21'd0, frame_num_o}, 32'd0);
    tick();
    finish_txn();
    check("sof_done_fn1", {21'd0, frame_num_o}, 32'd1);
    check("turnaround_idle", {31'd0, ctrl_gnt_o}, 32'd0);
    tick();
    check("ctrl_after_sof", {31'd0, ctrl_gnt_o}, 32'd1);
    ctrl_req_i = 1'b0;
    repeat (3) tick();
    check("ctrl_held_after_req_drop", {31'd0, ctrl_gnt_o}, 32'd1);
    finish_txn();

    // Control request inside the guard window: held off until the next
    // frame's SOF has completed.
    while (fc != 92) tick();
    check("eof_window_at_92", {31'd0, eof_window_o}, 32'd1);
    ctrl_req_i = 1'b1;
    expect_grant(K_SOF, 1);
    expect_grant(K_CTRL, 2);
    tick();
    check("guard_blocks_ctrl", {31'd0, busy_o}, 32'd0);
    wait_grant(n);
    check("guard_sof_first", {31'd0, sof_gnt_o}, 32'd1);
    tick();
    finish_txn();
    wait_grant(n);
    check("guard_ctrl", {31'd0, ctrl_gnt_o}, 32'd1);
    check("guard_ctrl_latency", n, 32'd1);
    ctrl_req_i = 1'b0;
    finish_txn();

    // Interrupt polling every second frame, starting after the first SOF.
    enable_i = 1'b0;
    tick();
    intr_en_i = 1'b1;
    enable_i  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expect_grant(K_SOF, 2 + i);
      if (i % 2 == 0) expect_grant(K_INTR, 3 + i);
      wait_grant(n);
      check("poll_sof", {31'd0, sof_gnt_o}, 32'd1);
      tick();
      finish_txn();
      if (i % 2 == 0) begin
        wait_grant(n);
        check("poll_intr", {31'd0, intr_gnt_o}, 32'd1);
        finish_txn();
      end
    end

    // Control transfer held across the frame wrap, done at frame_cnt=5.
    ctrl_req_i = 1'b1;
    expect_grant(K_CTRL, 8);
    wait_grant(n);
    check("wrap_ctrl", {31'd0, ctrl_gnt_o}, 32'd1);
    ctrl_req_i = 1'b0;
    while (fc != 0) tick();
    while (fc != 5) tick();
    check("wrap_ctrl_still", {31'd0, ctrl_gnt_o}, 32'd1);
    expect_grant(K_SOF, 8);
    txn_done_i = 1'b1;
    tick();
    txn_done_i = 1'b0;
    check("wrap_idle", {31'd0, busy_o}, 32'd0);
    tick();
    check("wrap_sof", {31'd0, sof_gnt_o}, 32'd1);
    check("wrap_fn", {21'd0, frame_num_o}, 32'd8);
    tick();
    finish_txn();

    // Disconnect during INTR: everything drops, frame number holds.
    expect_grant(K_INTR, 9);
    wait_grant(n);
    check("disc_intr", {31'd0, intr_gnt_o}, 32'd1);
    disconnect_i = 1'b1;
    txn_done_i   = 1'b1;
    tick();
    txn_done_i = 1'b0;
    check("disc_intr_drop", {31'd0, intr_gnt_o}, 32'd0);
    check("disc_busy", {31'd0, busy_o}, 32'd0);
    check("disc_fn", {21'd0, frame_num_o}, 32'd9);
    check("disc_eof", {31'd0, eof_window_o}, 32'd0);
    tick();
    intr_en_i    = 1'b0;
    disconnect_i = 1'b0;
    expect_grant(K_SOF, 9);
    wait_grant(n);
    check("reconnect_sof_latency", n, 32'd2);
    tick();
    finish_txn();
    check("reconnect_fn", {21'd0, frame_num_o}, 32'd10);

    // Reset in the middle of an SOF.
    expect_grant(K_SOF, 10);
    wait_grant(n);
    check("rst_mid_sof", {31'd0, sof_gnt_o}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("rst_mid_sof_drop", {31'd0, sof_gnt_o}, 32'd0);
    check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    check("rst_mid_fn", {21'd0, frame_num_o}, 32'd0);
    check("rst_mid_eof", {31'd0, eof_window_o}, 32'd0);
    rst_n = 1'b1;

    // Frame number rollover: re-enable forces an immediate SOF each time.
    for (int i = 0; i < 2048; i++) begin
      enable_i = 1'b0;
      tick();
      enable_i = 1'b1;
      expect_grant(K_SOF, i);
      wait_grant(n);
      finish_txn();
    end
    check("fn_rollover", {21'd0, frame_num_o}, 32'd0);

    repeat (2) tick();
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
